// File: rtl/timer_run_controller.sv
// rtl/timer_run_controller.sv - run/pause/lap sequencer for the two-digit timer
// Debounces the run and lap buttons and drives tick, clear and display-freeze to the counter chain.
module timer_run_controller #(
    parameter int TICK_DIV        = 25,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_lap,
    input  logic [7:0] count,
    output logic       tick_en,
    output logic       count_clr,
    output logic [7:0] disp_value,
    output logic       disp_frozen,
    output logic [1:0] state
);
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;
    localparam logic [1:0] LAP   = 2'b11;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // Bit 0 carries the run button, bit 1 the lap button.
    logic [1:0]    btn_raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    evt;
    logic [DW-1:0] db_cnt [2];

    logic          run_evt;
    logic          lap_evt;
    logic [1:0]    next_state;
    logic          clr_next;
    logic          frozen_next;
    logic          active;
    logic [PW-1:0] presc;

    assign btn_raw = {btn_lap, btn_run};

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            evt   <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                evt[i] <= 1'b0;
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    // Accept the new level; only a rising acceptance is an event.
                    db_cnt[i] <= '0;
                    deb[i]    <= sync2[i];
                    evt[i]    <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A simultaneous run press takes priority and swallows the lap press.
    assign run_evt = evt[0];
    assign lap_evt = evt[1] & ~evt[0];

    always_comb begin
        next_state  = state;
        clr_next    = 1'b0;
        frozen_next = disp_frozen;
        case (state)
            IDLE: begin
                if (run_evt) begin
                    next_state = RUN;
                end else if (lap_evt) begin
                    clr_next = 1'b1;
                end
            end
            RUN: begin
                if (run_evt) begin
                    next_state = PAUSE;
                end else if (lap_evt) begin
                    next_state  = LAP;
                    frozen_next = 1'b1;
                end
            end
            LAP: begin
                if (run_evt) begin
                    next_state  = PAUSE;
                    frozen_next = 1'b0;
                end else if (lap_evt) begin
                    next_state  = RUN;
                    frozen_next = 1'b0;
                end
            end
            default: begin
                if (run_evt) begin
                    next_state = RUN;
                end else if (lap_evt) begin
                    next_state = IDLE;
                    clr_next   = 1'b1;
                end
            end
        endcase
    end

    assign active  = (state == RUN) || (state == LAP);
    assign tick_en = active && (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state       <= IDLE;
            presc       <= '0;
            count_clr   <= 1'b0;
            disp_value  <= '0;
            disp_frozen <= 1'b0;
        end else begin
            state       <= next_state;
            count_clr   <= clr_next;
            disp_frozen <= frozen_next;
            if (!disp_frozen) begin
                disp_value <= count;
            end
            // Prescaler keeps its phase across PAUSE and restarts only from IDLE.
            if (next_state == IDLE) begin
                presc <= '0;
            end else if (tick_en) begin
                presc <= '0;
            end else if (active) begin
                presc <= presc + 1'b1;
            end
        end
    end
endmodule
